pingpong_pixel_buffer: RTL and testbench

PINGPONG_PIXEL_BUFFER -- requirements
Module: pingpong_pixel_buffer

---
 rtl/ppb_pkg.sv | 13 +
 rtl/ppb_sdp_ram.sv | 43 ++++
 rtl/pingpong_pixel_buffer.sv | 137 +++++++++++++
 tb/tb_pingpong_pixel_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppb_pkg.sv
// Shared types and constants for the ping-pong pixel buffer.
package ppb_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/ppb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are never reset; only the read register is.
module ppb_sdp_ram #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Sized by the full {bank, index} address space so non-power-of-two depths stay in range.
    localparam int unsigned WORDS = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pingpong_pixel_buffer.sv
// Two-bank ping-pong pixel buffer: fills A, B, A, ... and waits for a release before reuse.
// Optional macro PPB_DROP_ON_FULL_EN: never backpressure, drop and count pixels instead.
module pingpong_pixel_buffer
    import ppb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned BUFFER_DEPTH = 256,
    localparam int unsigned IDX_W       = $clog2(BUFFER_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_pixel_data,
    input  logic                  s_pixel_valid,
    output logic                  s_pixel_ready,
    output logic                  buffer_full_a,
    output logic                  buffer_full_b,
    input  logic                  bank_release_a,
    input  logic                  bank_release_b,
    input  logic                  rd_bank,
    input  logic [IDX_W-1:0]      rd_addr,
`ifdef PPB_DROP_ON_FULL_EN
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [15:0]           drop_count
`else
    output logic [DATA_WIDTH-1:0] rd_data
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_DEPTH - 1);

    bank_state_e      state_q [2];
    bank_state_e      state_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             full_a_q, full_a_d;
    logic             full_b_q, full_b_d;
    logic [1:0]       release_vec;
    logic             bank_writable;
    logic             accept;
    logic             last_write;

    assign release_vec   = {bank_release_b, bank_release_a};
    assign bank_writable = (state_q[wr_bank_q] != FULL);
    assign accept        = s_pixel_valid && bank_writable;
    assign last_write    = accept && (wr_idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0] <= FREE;
            state_q[1] <= FREE;
            wr_bank_q  <= BANK_A;
            wr_idx_q   <= '0;
            full_a_q   <= 1'b0;
            full_b_q   <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            wr_idx_q   <= wr_idx_d;
            full_a_q   <= full_a_d;
            full_b_q   <= full_b_d;
        end
    end

    // A release only touches FULL banks and an accept only touches a non-FULL bank,
    // so both can be applied in the same cycle without conflict.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (state_q[b] == FULL && release_vec[b]) begin
                state_d[b] = FREE;
            end
            if (accept && wr_bank_q == b[0]) begin
                state_d[b] = last_write ? FULL : FILLING;
            end
        end

        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        if (accept) begin
            if (last_write) begin
                wr_idx_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        full_a_d = last_write && (wr_bank_q == BANK_A);
        full_b_d = last_write && (wr_bank_q == BANK_B);
    end

    always_comb begin
`ifdef PPB_DROP_ON_FULL_EN
        s_pixel_ready = 1'b1;
`else
        s_pixel_ready = bank_writable;
`endif
        buffer_full_a = full_a_q;
        buffer_full_b = full_b_q;
    end

`ifdef PPB_DROP_ON_FULL_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (s_pixel_valid && !bank_writable && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    ppb_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (IDX_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr ({wr_bank_q, wr_idx_q}),
        .wdata (s_pixel_data),
        .raddr ({rd_bank, rd_addr}),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_pingpong_pixel_buffer.sv
// Self-checking bench for pingpong_pixel_buffer with BUFFER_DEPTH = 4, DATA_WIDTH = 24.
module tb_pingpong_pixel_buffer;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_pixel_data = '0;
    logic          s_pixel_valid = 1'b0;
    logic          s_pixel_ready;
    logic          buffer_full_a;
    logic          buffer_full_b;
    logic          bank_release_a = 1'b0;
    logic          bank_release_b = 1'b0;
    logic          rd_bank = 1'b0;
    logic [IW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
`ifdef PPB_DROP_ON_FULL_EN
    logic [15:0]   drop_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: bank contents, which banks are full, and the fill cursor.
    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_full [2];
    int            m_bank;
    int            m_idx;
    bit            m_pa, m_pb;
    logic [DW-1:0] m_rd;
    bit            m_rd_ok;
    int            m_drops;

    always #5 clk = ~clk;

    pingpong_pixel_buffer #(
        .DATA_WIDTH   (DW),
        .BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_pixel_data   (s_pixel_data),
        .s_pixel_valid  (s_pixel_valid),
        .s_pixel_ready  (s_pixel_ready),
        .buffer_full_a  (buffer_full_a),
        .buffer_full_b  (buffer_full_b),
        .bank_release_a (bank_release_a),
        .bank_release_b (bank_release_b),
        .rd_bank        (rd_bank),
        .rd_addr        (rd_addr),
`ifdef PPB_DROP_ON_FULL_EN
        .rd_data        (rd_data),
        .drop_count     (drop_count)
`else
        .rd_data        (rd_data)
`endif
    );

    function automatic bit m_ready();
`ifdef PPB_DROP_ON_FULL_EN
        return 1'b1;
`else
        return !m_full[m_bank];
`endif
    endfunction

    task automatic model_reset();
        m_full[0] = 0;
        m_full[1] = 0;
        m_bank    = 0;
        m_idx     = 0;
        m_pa      = 0;
        m_pb      = 0;
        m_drops   = 0;
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        s_pixel_valid  = 1'b0;
        bank_release_a = 1'b0;
        bank_release_b = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return at edge + 1.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit ra, input bit rb,
                        input bit rbk, input int radr);
        bit acc;
        s_pixel_valid  = v;
        s_pixel_data   = d;
        bank_release_a = ra;
        bank_release_b = rb;
        rd_bank        = rbk;
        rd_addr        = radr[IW-1:0];
        acc     = v && !m_full[m_bank];
        m_rd_ok = m_full[rbk];
        m_rd    = m_mem[rbk][radr];
        @(posedge clk);
        m_pa = 0;
        m_pb = 0;
        if (v && !acc) m_drops++;
        if (ra && m_full[0]) m_full[0] = 0;
        if (rb && m_full[1]) m_full[1] = 0;
        if (acc) begin
            m_mem[m_bank][m_idx] = d;
            if (m_idx == DEPTH - 1) begin
                m_full[m_bank] = 1;
                if (m_bank == 0) m_pa = 1;
                else m_pb = 1;
                m_idx  = 0;
                m_bank = 1 - m_bank;
            end else begin
                m_idx++;
            end
        end
        #1;
        bank_release_a = 1'b0;
        bank_release_b = 1'b0;
        s_pixel_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        checks++;
        if (s_pixel_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b want=1", s_pixel_ready);
        end
        checks++;
        if (buffer_full_a !== 1'b0) begin
            errors++; $display("FAIL reset_full_a got=%b want=0", buffer_full_a);
        end
        checks++;
        if (buffer_full_b !== 1'b0) begin
            errors++; $display("FAIL reset_full_b got=%b want=0", buffer_full_b);
        end
        checks++;
        if (rd_data !== '0) begin
            errors++; $display("FAIL reset_rd_data got=%h want=0", rd_data);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill_a();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1, DW'(i), 0, 0, 0, 0);
            checks++;
            if (buffer_full_a !== m_pa || buffer_full_b !== m_pb) begin
                errors++;
                $display("FAIL fill_a_pulse px=%0d got=%b%b want=%b%b", i,
                         buffer_full_a, buffer_full_b, m_pa, m_pb);
            end
        end
        checks++;
        if (buffer_full_a !== 1'b1) begin
            errors++; $display("FAIL fill_a_final_pulse got=%b want=1", buffer_full_a);
        end
        for (int a = 0; a < 4; a++) begin
            step(0, '0, 0, 0, 0, a);
            checks++;
            if (rd_data !== DW'(a + 1) || !m_rd_ok) begin
                errors++; $display("FAIL fill_a_read idx=%0d got=%h want=%h", a, rd_data, a + 1);
            end
            checks++;
            if (buffer_full_a !== 1'b0) begin
                errors++; $display("FAIL fill_a_pulse_width idx=%0d got=%b want=0", a, buffer_full_a);
            end
        end
    endtask

`ifndef PPB_DROP_ON_FULL_EN
    task automatic test_backpressure();
        logic [DW-1:0] p9;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, DW'($urandom), 0, 0, 0, 0);
            checks++;
            if (buffer_full_a !== m_pa || buffer_full_b !== m_pb || s_pixel_ready !== m_ready()) begin
                errors++;
                $display("FAIL bp_fill px=%0d got=%b%b%b want=%b%b%b", i, buffer_full_a,
                         buffer_full_b, s_pixel_ready, m_pa, m_pb, m_ready());
            end
        end
        checks++;
        if (s_pixel_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_low got=%b want=0", s_pixel_ready);
        end
        p9 = DW'($urandom);
        for (int i = 0; i < 3; i++) begin
            step(1, p9, 0, 0, 0, 0);
            checks++;
            if (s_pixel_ready !== 1'b0 || buffer_full_a !== 1'b0 || buffer_full_b !== 1'b0) begin
                errors++;
                $display("FAIL bp_held cyc=%0d got=%b%b%b want=000", i, s_pixel_ready,
                         buffer_full_a, buffer_full_b);
            end
        end
        step(1, p9, 1, 0, 0, 0);
        checks++;
        if (s_pixel_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got=%b want=1", s_pixel_ready);
        end
        step(1, p9, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, DW'($urandom), 0, 0, 0, 0);
        checks++;
        if (buffer_full_a !== 1'b1 || buffer_full_a !== m_pa) begin
            errors++; $display("FAIL bp_refill_pulse got=%b want=1", buffer_full_a);
        end
        step(0, '0, 0, 0, 0, 0);
        checks++;
        if (rd_data !== p9) begin
            errors++; $display("FAIL bp_ninth_pixel got=%h want=%h", rd_data, p9);
        end
    endtask
`endif

    task automatic test_reset_mid_fill();
        int pa;
        logic [DW-1:0] first;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, DW'($urandom), 0, 0, 0, 0);
            checks++;
            if (buffer_full_a !== 1'b0 || buffer_full_b !== 1'b0) begin
                errors++; $display("FAIL midrst_early_pulse got=%b%b want=00", buffer_full_a, buffer_full_b);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_pixel_ready !== 1'b1 || buffer_full_a !== 1'b0 || buffer_full_b !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_reset got=%b%b%b want=100", s_pixel_ready,
                     buffer_full_a, buffer_full_b);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pa = 0;
        first = DW'($urandom);
        for (int i = 0; i < 5; i++) begin
            step(i < 4, (i == 0) ? first : DW'($urandom), 0, 0, 0, 0);
            if (buffer_full_a === 1'b1) pa++;
            checks++;
            if (buffer_full_b !== 1'b0 || buffer_full_a !== m_pa) begin
                errors++;
                $display("FAIL midrst_refill cyc=%0d got=%b%b want=%b0", i, buffer_full_a,
                         buffer_full_b, m_pa);
            end
        end
        checks++;
        if (pa != 1) begin
            errors++; $display("FAIL midrst_pulse_count got=%0d want=1", pa);
        end
        step(0, '0, 0, 0, 0, 0);
        checks++;
        if (rd_data !== first) begin
            errors++; $display("FAIL midrst_restart_idx0 got=%h want=%h", rd_data, first);
        end
    endtask

    task automatic test_release_ignored();
        apply_reset();
        for (int i = 0; i < 6; i++) step(1, DW'($urandom), 0, 0, 0, 0);
        step(1, DW'($urandom), 0, 1, 0, 0);
        checks++;
        if (s_pixel_ready !== 1'b1 || buffer_full_b !== 1'b0) begin
            errors++; $display("FAIL relb_ignored got=%b%b want=10", s_pixel_ready, buffer_full_b);
        end
        step(1, DW'($urandom), 0, 0, 0, 0);
        checks++;
        if (buffer_full_b !== 1'b1 || buffer_full_b !== m_pb) begin
            errors++; $display("FAIL relb_pulse got=%b want=1", buffer_full_b);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            checks++;
            if (s_pixel_ready !== m_ready() || buffer_full_a !== m_pa || buffer_full_b !== m_pb) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got=%b%b%b want=%b%b%b", n, s_pixel_ready,
                         buffer_full_a, buffer_full_b, m_ready(), m_pa, m_pb);
            end
            if (m_rd_ok) begin
                checks++;
                if (rd_data !== m_rd) begin
                    errors++; $display("FAIL rand_read cyc=%0d got=%h want=%h", n, rd_data, m_rd);
                end
            end
        end
    endtask

`ifdef PPB_DROP_ON_FULL_EN
    task automatic test_drop();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, DW'($urandom), 0, 0, 0, 0);
            checks++;
            if (s_pixel_ready !== 1'b1) begin
                errors++; $display("FAIL drop_ready px=%0d got=%b want=1", i, s_pixel_ready);
            end
        end
        checks++;
        if (drop_count !== 16'd2 || m_drops != 2) begin
            errors++; $display("FAIL drop_count got=%0d want=2", drop_count);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_fill_a();
`ifndef PPB_DROP_ON_FULL_EN
        test_backpressure();
`endif
        test_reset_mid_fill();
        test_release_ignored();
        test_random();
`ifdef PPB_DROP_ON_FULL_EN
        test_drop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
